dec_arbiter2: RTL and testbench

DEC_ARBITER2 -- requirements
Module: dec_arbiter2

---
 rtl/dec_arbiter2.sv | 102 ++++++++++
 tb/tb_dec_arbiter2.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dec_arbiter2.sv
// Two-requester arbiter driving a 1-to-2 decoder. Grants are round-robin on
// ties, an owner may hold the resource indefinitely while uncontested, and an
// owner is preempted after MAX_HOLD consecutive cycles when the other side waits.
// Every grant is followed by at least one idle cycle before the next.
module dec_arbiter2 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       dec_in,
  output logic       dec_en,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic [7:0] grant_count
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_dec_in;
  logic        r_last_owner;
  logic [3:0]  r_hold_cnt;
  logic [7:0]  r_grant_count;

  logic        w_owner_req;
  logic        w_other_req;
  logic        w_hold_last;
  logic        w_grant_sel;
  logic        w_start;
  logic        w_stay;

  // While granted, r_dec_in names the current owner.
  assign w_owner_req = r_dec_in ? req1 : req0;
  assign w_other_req = r_dec_in ? req0 : req1;
  assign w_hold_last = (r_hold_cnt == HoldLast);
  assign w_start     = (r_state == StIdle)  && (w_state_next == StGrant);
  assign w_stay      = (r_state == StGrant) && (w_state_next == StGrant);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and winner selection; a tie goes to whoever did not own last.
  always_comb begin
    w_state_next = r_state;
    w_grant_sel  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req0 || req1) begin
          w_state_next = StGrant;
          w_grant_sel  = (req0 && req1) ? ~r_last_owner : req1;
        end
      end
      StGrant: begin
        if (!w_owner_req || (w_hold_last && w_other_req)) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Grant bookkeeping: owner, round-robin memory, hold counter, grant tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_in      <= 1'b0;
      r_last_owner  <= 1'b1;
      r_hold_cnt    <= 4'd0;
      r_grant_count <= 8'd0;
    end else if (w_start) begin
      r_dec_in      <= w_grant_sel;
      r_last_owner  <= w_grant_sel;
      r_hold_cnt    <= 4'd0;
      r_grant_count <= r_grant_count + 8'd1;
    end else if (w_stay) begin
      // Uncontested owner keeps the grant; counter restarts its window.
      r_hold_cnt <= w_hold_last ? 4'd0 : r_hold_cnt + 4'd1;
    end
  end

  // Outputs: enable/busy come straight from the state flop, grants decode it.
  always_comb begin
    dec_en      = (r_state == StGrant);
    busy        = (r_state == StGrant);
    dec_in      = r_dec_in;
    gnt0        = dec_en & ~dec_in;
    gnt1        = dec_en & dec_in;
    grant_count = r_grant_count;
  end

endmodule

// File: tb/tb_dec_arbiter2.sv
// Randomized and directed bench for dec_arbiter2 against a rule-level model.
module tb_dec_arbiter2;

  localparam int MaxHold = 4;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req1;
  logic       dec_in;
  logic       dec_en;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic [7:0] grant_count;

  int n_cmp;
  int n_bad;

  // Model: whether a grant is live, who owns it, how long it has run.
  bit m_gr;
  bit m_din;
  bit m_last;
  int m_held;
  int m_cnt;

  dec_arbiter2 #(.MAX_HOLD(MaxHold)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .dec_in     (dec_in),
    .dec_en     (dec_en),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .busy       (busy),
    .grant_count(grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs from the rules, not from any state encoding.
  task automatic model_edge(input bit r, input bit a, input bit b);
    bit mine;
    bit other;
    if (r) begin
      m_gr = 0; m_din = 0; m_cnt = 0; m_last = 1; m_held = 0;
    end else if (!m_gr) begin
      if (a || b) begin
        m_din  = (a && b) ? !m_last : b;
        m_last = m_din;
        m_gr   = 1;
        m_held = 1;
        m_cnt  = (m_cnt + 1) % 256;
      end
    end else begin
      mine  = m_din ? b : a;
      other = m_din ? a : b;
      if (!mine) m_gr = 0;
      else if (other && (m_held % MaxHold == 0)) m_gr = 0;
      else m_held++;
    end
  endtask

  task automatic step(input bit r, input bit a, input bit b);
    @(negedge clk);
    rst  = r;
    req0 = a;
    req1 = b;
    @(posedge clk);
    model_edge(r, a, b);
    #1;
    check_eq("dec_en", {7'd0, dec_en}, {7'd0, m_gr});
    check_eq("busy", {7'd0, busy}, {7'd0, m_gr});
    check_eq("dec_in", {7'd0, dec_in}, {7'd0, m_din});
    check_eq("gnt0", {7'd0, gnt0}, {7'd0, m_gr && !m_din});
    check_eq("gnt1", {7'd0, gnt1}, {7'd0, m_gr && m_din});
    check_eq("grant_count", grant_count, 8'(m_cnt));
    check_eq("gnt_excl", {7'd0, gnt0 & gnt1}, 8'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_gr = 0; m_din = 0; m_last = 1; m_held = 0; m_cnt = 0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;

    // Reset, then requester 0 alone holds indefinitely.
    repeat (3) step(1, 1, 1);
    repeat (14) step(0, 1, 0);
    check_eq("solo_count", grant_count, 8'd1);
    repeat (2) step(0, 0, 0);

    // Both held from reset: alternating 4-on / 1-dead pattern.
    step(1, 0, 0);
    repeat (30) step(0, 1, 1);

    // Requester 1 owns, then drops: idle with dec_in kept at 1.
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    check_eq("drop_dec_in", {7'd0, dec_in}, 8'd1);
    check_eq("drop_dec_en", {7'd0, dec_en}, 8'd0);

    // Build a count of 5, reset mid-grant, requester 0 wins afterwards.
    step(1, 0, 0);
    repeat (4) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    step(0, 1, 1);
    step(0, 1, 1);
    check_eq("pre_rst_count", grant_count, 8'd5);
    step(1, 1, 1);
    check_eq("rst_count", grant_count, 8'd0);
    step(0, 1, 1);
    check_eq("post_rst_gnt0", {7'd0, gnt0}, 8'd1);
    repeat (6) step(0, 1, 1);

    // 256 single-cycle grants wrap the counter.
    step(1, 0, 0);
    repeat (256) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    check_eq("wrap_count", grant_count, 8'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
